// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a length-prefixed byte stream into 32-bit RAM writes
// and holds the core in reset until the new program is fully written.
module imem_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_len;
  logic [15:0] r_word_cnt;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_asm;
  logic [31:0] r_addr;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        w_xfer;
  logic        w_start_ok;
  logic [15:0] w_len_full;
  logic        w_len_zero;
  logic        w_len_over;
  logic        w_last_word;

  assign w_xfer      = in_valid && in_ready;
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_ERR));
  assign w_len_full  = {r_len[15:8], in_byte};
  assign w_len_zero  = (w_len_full == 16'd0);
  assign w_len_over  = ({16'd0, w_len_full} > 32'(DEPTH));
  assign w_last_word = ((r_word_cnt + 16'd1) == r_len);

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    load_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) begin
          if (w_len_zero)      w_next = S_DONE;
          else if (w_len_over) w_next = S_ERR;
          else                 w_next = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        mem_we   = 1'b1;
        cpu_hold = 1'b1;
        w_next   = w_last_word ? S_DONE : S_DATA;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b1;
        w_next   = S_IDLE;
      end
      S_ERR: begin
        load_err = 1'b1;
        if (start) w_next = S_LEN_HI;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: length capture, word assembly, write address/data staging.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len       <= 16'd0;
      r_word_cnt  <= 16'd0;
      r_byte_cnt  <= 2'd0;
      r_asm       <= 24'd0;
      r_addr      <= BASE_ADDR;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      if (w_start_ok) begin
        r_addr     <= BASE_ADDR;
        r_word_cnt <= 16'd0;
        r_byte_cnt <= 2'd0;
      end
      if ((r_state == S_LEN_HI) && w_xfer) r_len[15:8] <= in_byte;
      if ((r_state == S_LEN_LO) && w_xfer) r_len[7:0]  <= in_byte;
      if ((r_state == S_DATA) && w_xfer) begin
        r_asm      <= {r_asm[15:0], in_byte};
        r_byte_cnt <= r_byte_cnt + 2'd1;
        // Stage the word on the 4th byte so it is on the bus during WRITE.
        if (r_byte_cnt == 2'd3) begin
          r_mem_addr  <= r_addr;
          r_mem_wdata <= {r_asm, in_byte};
        end
      end
      if (r_state == S_WRITE) begin
        r_addr     <= r_addr + 32'd4;
        r_word_cnt <= r_word_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: basic load, stalls, empty program, overflow,
// reset mid-word and spurious start, with hand-computed write sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        load_err;

  int vectors = 0;
  int errors  = 0;
  int we_cnt  = 0;

  imem_loader #(.DEPTH(1024), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we === 1'b1) we_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic chk_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_we"},   {31'd0, mem_we}, 32'd1);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_data"}, mem_wdata, d);
  endtask

  task automatic chk_finish(input string tag);
    tick();
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_hold_in_done"}, {31'd0, cpu_hold}, 32'd1);
    tick();
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_hold_low"}, {31'd0, cpu_hold}, 32'd0);
  endtask

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_we",    {31'd0, mem_we},   32'd0);
    chk("rst_addr",  mem_addr,          32'd0);
    chk("rst_wdata", mem_wdata,         32'd0);
    chk("rst_hold",  {31'd0, cpu_hold}, 32'd0);
    chk("rst_done",  {31'd0, done},     32'd0);
    chk("rst_err",   {31'd0, load_err}, 32'd0);

    // T1 basic two-word load
    base = we_cnt;
    pulse_start();
    chk("t1_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t1_ready", {31'd0, in_ready}, 32'd1);
    send(8'h00, 0); send(8'h02, 0);
    send(8'h80, 0); send(8'h01, 0); send(8'h06, 0); send(8'h0A, 0);
    chk_write("t1_w0", 32'h0, 32'h8001060A);
    chk("t1_w0_nodone", {31'd0, done}, 32'd0);
    send(8'h04, 0); send(8'h01, 0); send(8'h10, 0); send(8'h00, 0);
    chk_write("t1_w1", 32'h4, 32'h04011000);
    chk_finish("t1");
    chk("t1_addr_hold", mem_addr, 32'h4);
    chk("t1_wcount", we_cnt - base, 2);

    // T2 same stream with 3-cycle stalls
    base = we_cnt;
    pulse_start();
    send(8'h00, 3); send(8'h02, 3);
    send(8'h80, 3);
    chk("t2_ready_data", {31'd0, in_ready}, 32'd1);
    chk("t2_no_we", {31'd0, mem_we}, 32'd0);
    send(8'h01, 3); send(8'h06, 3); send(8'h0A, 0);
    chk_write("t2_w0", 32'h0, 32'h8001060A);
    tick(); tick(); tick();
    chk("t2_ready_after_w0", {31'd0, in_ready}, 32'd1);
    send(8'h04, 3); send(8'h01, 3); send(8'h10, 3); send(8'h00, 0);
    chk_write("t2_w1", 32'h4, 32'h04011000);
    chk_finish("t2");
    chk("t2_wcount", we_cnt - base, 2);

    // T3 empty program
    base = we_cnt;
    pulse_start();
    send(8'h00, 0); send(8'h00, 0);
    chk("t3_done", {31'd0, done}, 32'd1);
    tick();
    chk("t3_hold_low", {31'd0, cpu_hold}, 32'd0);
    chk("t3_wcount", we_cnt - base, 0);

    // T4 overflow then recovery
    base = we_cnt;
    pulse_start();
    send(8'h04, 0); send(8'h01, 0);
    chk("t4_err", {31'd0, load_err}, 32'd1);
    chk("t4_ready", {31'd0, in_ready}, 32'd0);
    chk("t4_hold", {31'd0, cpu_hold}, 32'd0);
    in_valid = 1'b1; in_byte = 8'h55;
    tick(); tick(); tick();
    in_valid = 1'b0;
    chk("t4_err_sticky", {31'd0, load_err}, 32'd1);
    chk("t4_nowrite", we_cnt - base, 0);
    pulse_start();
    chk("t4_err_clr", {31'd0, load_err}, 32'd0);
    send(8'h00, 0); send(8'h01, 0);
    send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 0);
    chk_write("t4_w0", 32'h0, 32'hDEADBEEF);
    chk_finish("t4");

    // T5 reset after two data bytes
    pulse_start();
    send(8'h00, 0); send(8'h01, 0); send(8'h80, 0); send(8'h01, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_ready", {31'd0, in_ready}, 32'd0);
    chk("t5_hold",  {31'd0, cpu_hold}, 32'd0);
    chk("t5_we",    {31'd0, mem_we},   32'd0);
    chk("t5_addr",  mem_addr,          32'd0);
    chk("t5_wdata", mem_wdata,         32'd0);
    chk("t5_done",  {31'd0, done},     32'd0);
    pulse_start();
    send(8'h00, 0); send(8'h01, 0);
    send(8'h80, 0); send(8'h01, 0); send(8'h06, 0); send(8'h0A, 0);
    chk_write("t5_w0", 32'h0, 32'h8001060A);
    chk_finish("t5");

    // T6 start pulsed during DATA is ignored
    base = we_cnt;
    pulse_start();
    send(8'h00, 0); send(8'h02, 0); send(8'h80, 0); send(8'h01, 0);
    pulse_start();
    chk("t6_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t6_ready", {31'd0, in_ready}, 32'd1);
    send(8'h06, 0); send(8'h0A, 0);
    chk_write("t6_w0", 32'h0, 32'h8001060A);
    send(8'h04, 0); send(8'h01, 0); send(8'h10, 0); send(8'h00, 0);
    chk_write("t6_w1", 32'h4, 32'h04011000);
    chk_finish("t6");
    chk("t6_wcount", we_cnt - base, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
